data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store controller for a byte-addressed array of 32-bit words, with optional wait states.
// Define CROSS_SPLIT_EN to split word-crossing accesses over two array cycles; otherwise they fault.
module data_mem_ctrl #(
    parameter int    ADDR_WIDTH  = 12,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;
`ifdef CROSS_SPLIT_EN
    localparam int SPAN = 2;
`else
    localparam int SPAN = 1;
`endif
    localparam int BE_W = 4 * SPAN;
    localparam int DW   = 32 * SPAN;

    typedef enum logic [2:0] {IDLE, WAIT, ACC1, ACC2, RESP} state_t;
    state_t state, next_state;

    logic [31:0]      mem [DEPTH];
    logic [3:0]       wait_cnt;
    logic             handshake;
    logic             we_lo;

    logic [2:0]       nbytes;
    logic [3:0]       mask;
    logic [31:0]      wdata_lsb;
    logic [32:0]      last_byte;
    logic             crossing;
    logic             acc_fault;
    logic [BE_W-1:0]  be_acc;
    logic [DW-1:0]    wd_acc;

    logic             r_write;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [1:0]       r_off;
    logic [IDX_W-1:0] r_idx;
    logic             r_fault;
    logic [BE_W-1:0]  r_be;
    logic [DW-1:0]    r_wd;

    logic [DW-1:0]    rd_full;
    logic [31:0]      rd_sh;
    logic [31:0]      load_val;

    // Classify the incoming request so only its lane-aligned form is captured at accept.
    always_comb begin
        nbytes    = 3'd1;
        mask      = 4'b0001;
        wdata_lsb = {24'b0, req_wdata[7:0]};
        case (req_size)
            2'b01: begin
                nbytes    = 3'd2;
                mask      = 4'b0011;
                wdata_lsb = {16'b0, req_wdata[15:0]};
            end
            2'b10: begin
                nbytes    = 3'd4;
                mask      = 4'b1111;
                wdata_lsb = req_wdata;
            end
            default: ;
        endcase
        crossing  = ({1'b0, req_addr[1:0]} + nbytes) > 3'd4;
        last_byte = {1'b0, req_addr} + {30'b0, nbytes} - 33'd1;
        acc_fault = (req_size == 2'b11) || (|last_byte[32:ADDR_WIDTH])
`ifndef CROSS_SPLIT_EN
                    || crossing
`endif
                    ;
        be_acc = BE_W'(mask) << req_addr[1:0];
        wd_acc = DW'(wdata_lsb) << {req_addr[1:0], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

`ifdef CROSS_SPLIT_EN
    logic             r_cross;
    logic [31:0]      lo_word;
    logic [IDX_W-1:0] idx_next;
    logic             we_hi;
    assign idx_next = r_idx + IDX_W'(1);
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (handshake) next_state = (WAIT_STATES > 0) ? WAIT : ACC1;
            WAIT: if (wait_cnt == 4'(WAIT_STATES - 1)) next_state = ACC1;
`ifdef CROSS_SPLIT_EN
            ACC1: next_state = (r_cross && !r_fault) ? ACC2 : RESP;
            ACC2: next_state = RESP;
`else
            ACC1: next_state = RESP;
`endif
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        handshake  = req_valid && (state == IDLE);
        we_lo      = (state == ACC1) && r_write && !r_fault;
`ifdef CROSS_SPLIT_EN
        we_hi      = (state == ACC2) && r_write && !r_fault;
`endif
    end

`ifdef CROSS_SPLIT_EN
    assign rd_full = (state == ACC2) ? {mem[idx_next], lo_word} : {32'b0, mem[r_idx]};
`else
    assign rd_full = mem[r_idx];
`endif
    assign rd_sh = 32'(rd_full >> {r_off, 3'b000});

    always_comb begin
        case (r_size)
            2'b00:   load_val = r_unsigned ? {24'b0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_val = r_unsigned ? {16'b0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: load_val = rd_sh;
        endcase
    end

    // A reset coinciding with an access edge must suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && we_lo)
            for (int b = 0; b < 4; b++)
                if (r_be[b]) mem[r_idx][8*b +: 8] <= r_wd[8*b +: 8];
`ifdef CROSS_SPLIT_EN
        if (!rst && we_hi)
            for (int b = 0; b < 4; b++)
                if (r_be[4+b]) mem[idx_next][8*b +: 8] <= r_wd[32+8*b +: 8];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            if (handshake) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_off      <= req_addr[1:0];
                r_idx      <= req_addr[ADDR_WIDTH-1:2];
                r_fault    <= acc_fault;
                r_be       <= be_acc;
                r_wd       <= wd_acc;
`ifdef CROSS_SPLIT_EN
                r_cross    <= crossing;
`endif
                wait_cnt   <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
`ifdef CROSS_SPLIT_EN
            if (state == ACC1)
                lo_word <= mem[r_idx];
`endif
            if (next_state == RESP) begin
                resp_fault <= r_fault;
                resp_rdata <= (r_write || r_fault) ? 32'b0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one zero-wait instance driven from a vector table,
// one three-wait instance for handshake timing and reset-abort sequences.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_valid0, req_ready0, resp_valid0, resp_fault0;
    logic [31:0] resp_rdata0;
    logic        req_valid3, req_ready3, resp_valid3, resp_fault3;
    logic [31:0] resp_rdata3;

    int asserts  = 0;
    int failures = 0;

`ifdef CROSS_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_fault(resp_fault0)
    );

    data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_fault(resp_fault3)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_fault,
                                int exp_lat);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction on the selected instance; request inputs are scrambled once accepted.
    task automatic applyStimulus(input bit sel, input vec_t v, output logic [31:0] rdata,
                                 output logic fault, output int lat, output int ready_low);
        @(posedge clk); #1;
        checkOutput("ready_before_req", {31'b0, sel ? req_ready3 : req_ready0}, 32'd1);
        req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        if (sel) req_valid3 = 1'b1; else req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_valid3 = 1'b0;
        req_write = ~v.wr; req_size = 2'b10; req_addr = 32'h0000_0FFC; req_wdata = 32'h5555_AAAA;
        lat = -1; ready_low = 0; rdata = 32'hxxxx_xxxx; fault = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            if (!(sel ? req_ready3 : req_ready0)) ready_low++;
            if (sel ? resp_valid3 : resp_valid0) begin
                lat   = n;
                rdata = sel ? resp_rdata3 : resp_rdata0;
                fault = sel ? resp_fault3 : resp_fault0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Start a store on the wait-state instance and reset it in cycle T+at.
    task automatic resetDuringStore(input int at, input string tag);
        int seen;
        seen = 0;
        @(posedge clk); #1;
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'hFFFF_FFFF;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        for (int k = 1; k < at; k++) begin
            if (resp_valid3) seen++;
            @(posedge clk); #1;
        end
        if (resp_valid3) seen++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput({tag, "_ready"}, {31'b0, req_ready3}, 32'd1);
        checkOutput({tag, "_rdata_cleared"}, resp_rdata3, 32'h0);
        checkOutput({tag, "_fault_cleared"}, {31'b0, resp_fault3}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (resp_valid3) seen++;
            @(posedge clk); #1;
        end
        checkOutput({tag, "_no_resp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ft;
        int          lat, rlow;

        rst = 1'b1; req_valid0 = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        // Table: write, size, unsigned, addr, wdata, expected rdata, fault, latency
        vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0, 2));
        vecs.push_back(mk(0, 2'b00, 0, 32'h013, 32'h0, 32'hFFFFFFDE, 0, 2));
        vecs.push_back(mk(0, 2'b00, 1, 32'h013, 32'h0, 32'h000000DE, 0, 2));
        vecs.push_back(mk(1, 2'b01, 0, 32'h012, 32'hABCD1234, 32'h0, 0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h010, 32'h0, 32'h1234BEEF, 0, 2));
        vecs.push_back(mk(0, 2'b01, 0, 32'h010, 32'h0, 32'hFFFFBEEF, 0, 2));
        vecs.push_back(mk(0, 2'b01, 1, 32'h012, 32'h0, 32'h00001234, 0, 2));
        vecs.push_back(mk(1, 2'b00, 0, 32'h011, 32'hFFFFFF5A, 32'h0, 0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h010, 32'h0, 32'h12345AEF, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'hFFC, 32'h0BADF00D, 32'h0, 0, 2));
        vecs.push_back(mk(1, 2'b01, 0, 32'hFFE, 32'h00007777, 32'h0, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'hFFE, 32'h11111111, 32'h0, 1, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'hFFC, 32'h0, 32'h7777F00D, 0, 2));
        vecs.push_back(mk(0, 2'b00, 1, 32'hFFF, 32'h0, 32'h00000077, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'h000, 32'h11223344, 32'h0, 0, 2));
        vecs.push_back(mk(1, 2'b11, 0, 32'h000, 32'hFFFFFFFF, 32'h0, 1, 2));
        vecs.push_back(mk(0, 2'b11, 0, 32'h000, 32'h0, 32'h0, 1, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h000, 32'h0, 32'h11223344, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'h020, 32'h55667788, 32'h0, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'h024, 32'h99AABBCC, 32'h0, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'h021, 32'hA1B2C3D4, 32'h0, !SPLIT, SPLIT ? 3 : 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h021, 32'h0, SPLIT ? 32'hA1B2C3D4 : 32'h0, !SPLIT, SPLIT ? 3 : 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h020, 32'h0, SPLIT ? 32'hB2C3D488 : 32'h55667788, 0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h024, 32'h0, SPLIT ? 32'h99AABBA1 : 32'h99AABBCC, 0, 2));
        vecs.push_back(mk(0, 2'b01, 0, 32'h023, 32'h0, SPLIT ? 32'hFFFFA1B2 : 32'h0, !SPLIT, SPLIT ? 3 : 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 2));
        vecs.push_back(mk(0, 2'b01, 1, 32'h011, 32'h0, 32'h0000345A, 0, 2));

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_resp_valid", {31'b0, resp_valid0}, 32'd0);
        checkOutput("reset_rdata", resp_rdata0, 32'h0);
        checkOutput("reset_fault", {31'b0, resp_fault0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_reset0", {31'b0, req_ready0}, 32'd1);
        checkOutput("ready_after_reset3", {31'b0, req_ready3}, 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i], rd, ft, lat, rlow);
            checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_fault", i), {31'b0, ft}, {31'b0, vecs[i].exp_fault});
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Response fields must hold after the pulse.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold_resp_valid", {31'b0, resp_valid0}, 32'd0);
        checkOutput("hold_rdata", resp_rdata0, 32'h0000345A);

        applyStimulus(1'b1, mk(1, 2'b10, 0, 32'h050, 32'h01020304, 0, 0, 5), rd, ft, lat, rlow);
        checkOutput("ws3_store50_latency", 32'(lat), 32'd5);
        applyStimulus(1'b1, mk(1, 2'b10, 0, 32'h040, 32'hCAFEF00D, 0, 0, 5), rd, ft, lat, rlow);
        checkOutput("ws3_store40_latency", 32'(lat), 32'd5);
        checkOutput("ws3_store40_ready_low", 32'(rlow), 32'd5);
        checkOutput("ws3_store40_fault", {31'b0, ft}, 32'd0);
        applyStimulus(1'b1, mk(0, 2'b10, 0, 32'h040, 32'h0, 0, 0, 5), rd, ft, lat, rlow);
        checkOutput("ws3_load40_rdata", rd, 32'hCAFEF00D);
        checkOutput("ws3_load40_latency", 32'(lat), 32'd5);
        checkOutput("ws3_load40_ready_low", 32'(rlow), 32'd5);

        resetDuringStore(3, "rst_t3");
        resetDuringStore(4, "rst_t4_acc1");

        applyStimulus(1'b1, mk(0, 2'b10, 0, 32'h050, 32'h0, 0, 0, 5), rd, ft, lat, rlow);
        checkOutput("ws3_load50_after_rst", rd, 32'h01020304);
        checkOutput("ws3_load50_fault", {31'b0, ft}, 32'd0);
        checkOutput("ws3_load50_latency", 32'(lat), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
